vx_pending_gate: RTL

Credit gate between a request producer and a memory-side consumer. It accepts requests on an elastic input and forwards them through a one-entry registered output stage. It counts accepted-but-unretired requests and back-pressures the producer once MAX_PENDING are outstanding. A level-sensitive flush handshake stops intake and reports when all outstanding requests have retired, for use by fence, barrier and cache-flush paths.

---
 rtl/vx_pending_gate_pkg.sv | 14 +
 rtl/vx_pending_gate_obuf.sv | 37 +++
 rtl/vx_pending_gate.sv | 109 ++++++++++
 3 files changed

// File: rtl/vx_pending_gate_pkg.sv
// Shared types for the pending-request credit gate.
package vx_pending_gate_pkg;

   typedef enum logic [1:0] {
      GATE_RUN,
      GATE_DRAIN,
      GATE_DONE
   } gate_state_e;

   function automatic int cnt_width(input int max_pending);
      return $clog2(max_pending + 1);
   endfunction

endpackage

// File: rtl/vx_pending_gate_obuf.sv
// One-entry registered output stage: loads on accept, clears when the consumer
// takes it, and a simultaneous load replaces the entry. Valid has async reset, payload does not.
module vx_pending_gate_obuf #(
   parameter int DATAW = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DATAW-1:0] data_in,
   input  logic             ready_out,
   output logic             valid_out,
   output logic [DATAW-1:0] data_out
);

   logic             valid_q;
   logic [DATAW-1:0] data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
      end else if (valid_q && ready_out) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= data_in;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;

endmodule

// File: rtl/vx_pending_gate.sv
// Credit gate: caps accepted-but-unretired requests at MAX_PENDING, forwards
// them through a one-entry output stage, and drains on a level flush handshake.
module vx_pending_gate
   import vx_pending_gate_pkg::*;
#(
   parameter  int DATAW       = 1,
   parameter  int MAX_PENDING = 4,
   parameter  int DECRW       = 1,
   localparam int CNTW        = cnt_width(MAX_PENDING)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_in,
   input  logic [DATAW-1:0] req_data_in,
   output logic             req_ready_in,
   output logic             req_valid_out,
   output logic [DATAW-1:0] req_data_out,
   input  logic             req_ready_out,
   input  logic [DECRW-1:0] rsp_retire,
   input  logic             flush_req,
   output logic             flush_done,
   output logic [CNTW-1:0]  pending_size,
   output logic             empty,
   output logic             full
);

   localparam int CW1 = CNTW + 1;

   gate_state_e     state;
   gate_state_e     state_n;
   logic [CNTW-1:0] cnt;
   logic            empty_q;
   logic            full_q;
   logic            obuf_valid;
   logic            acc;
   logic [CW1-1:0]  sum;
   logic [CW1-1:0]  cnt_n_wide;
   logic [CNTW-1:0] cnt_n;
   logic            underflow;

   // Reset is folded in so the producer never sees ready while the gate is held.
   assign req_ready_in = ~reset & (state == GATE_RUN) & ~full_q
                         & (~obuf_valid | req_ready_out);
   assign acc = req_valid_in & req_ready_in;

   always_comb begin
      sum        = {1'b0, cnt} + CW1'(acc);
      underflow  = CW1'(rsp_retire) > sum;
      cnt_n_wide = underflow ? '0 : sum - CW1'(rsp_retire);
      cnt_n      = cnt_n_wide[CNTW-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         state   <= GATE_RUN;
      end else begin
         cnt     <= cnt_n;
         empty_q <= (cnt_n == '0);
         full_q  <= (cnt_n == CNTW'(MAX_PENDING));
         state   <= state_n;
      end
   end

   // Once draining, the gate always completes to DONE before returning to RUN.
   always_comb begin
      state_n = state;
      case (state)
         GATE_RUN: begin
            if (flush_req) state_n = GATE_DRAIN;
         end
         GATE_DRAIN: begin
            if ((cnt == '0) && !obuf_valid) state_n = GATE_DONE;
         end
         GATE_DONE: begin
            if (!flush_req) state_n = GATE_RUN;
         end
         default: state_n = GATE_RUN;
      endcase
   end

   vx_pending_gate_obuf #(
      .DATAW (DATAW)
   ) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .load      (acc),
      .data_in   (req_data_in),
      .ready_out (req_ready_out),
      .valid_out (obuf_valid),
      .data_out  (req_data_out)
   );

   assign req_valid_out = obuf_valid;
   assign flush_done    = (state == GATE_DONE);
   assign pending_size  = cnt;
   assign empty         = empty_q;
   assign full          = full_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!underflow);
         assert (cnt_n_wide <= CW1'(MAX_PENDING));
      end
   end

endmodule
